// File: rtl/riscv_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_monitor_pkg
// Description : Shared types and default constants for the end-of-program
//               monitor and the core benches.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_monitor_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } mon_state_e;

    localparam logic [31:0] c_DONE_ADDR  = 32'd100;
    localparam logic [31:0] c_PASS_VALUE = 32'd25;

    function automatic logic is_terminal(input mon_state_e s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_end_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_end_monitor_if
// Description : Core-side snoop bus (data-memory write port + retire pulse).
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_end_monitor_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              instr_retire;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output instr_retire
    );

    modport slave (
        input mem_we,
        input mem_addr,
        input mem_wdata,
        input instr_retire
    );
endinterface
`default_nettype wire

// File: rtl/riscv_end_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    output logic      [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/riscv_end_monitor.sv
`default_nettype none
// ============================================================================
// Module      : riscv_end_monitor
// Description : Sequences core reset, detects the done-address write and
//               reports pass/fail/timeout with cycle and retire counts.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_end_monitor
    import riscv_monitor_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter logic [ADDR_W-1:0] DONE_ADDR      = ADDR_W'(c_DONE_ADDR),
    parameter logic [DATA_W-1:0] PASS_VALUE     = DATA_W'(c_PASS_VALUE),
    parameter int unsigned       RESET_HOLD     = 4,
    parameter int unsigned       TIMEOUT_CYCLES = 1000,
    parameter int unsigned       CNT_W          = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    riscv_end_monitor_if.slave     bus,
    output logic                   core_reset,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic       [2:0]       state_o,
    output logic       [CNT_W-1:0] cycle_count,
    output logic       [CNT_W-1:0] instr_count
);

    localparam logic [3:0]  c_HOLD_LAST    = 4'(RESET_HOLD - 1);
    localparam logic [63:0] c_TIMEOUT_LAST = 64'(TIMEOUT_CYCLES - 1);

    mon_state_e r_state;
    mon_state_e w_state_nxt;
    logic [3:0] r_hold;
    logic       r_core_reset;
    logic       r_done;
    logic       r_pass;
    logic       r_fail;
    logic       r_timeout;

    logic       w_done_wr;
    logic       w_pass_val;
    logic       w_timeout_hit;
    logic       w_cyc_en;
    logic       w_ins_en;
    logic       w_cnt_clr;

    assign w_done_wr     = bus.mem_we && (bus.mem_addr == DONE_ADDR);
    assign w_pass_val    = (bus.mem_wdata == PASS_VALUE);
    // Widened compare so narrow counters never alias onto the limit.
    assign w_timeout_hit = (64'(cycle_count) == c_TIMEOUT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HOLD: begin
                if (r_hold == c_HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_done_wr) begin
                    w_state_nxt = w_pass_val ? ST_PASS : ST_FAIL;
                end else if (w_timeout_hit) begin
                    w_state_nxt = ST_TIMEOUT;
                end
            end
            ST_PASS:    w_state_nxt = ST_PASS;
            ST_FAIL:    w_state_nxt = ST_FAIL;
            ST_TIMEOUT: w_state_nxt = ST_TIMEOUT;
            default:    w_state_nxt = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flags are derived from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold       <= 4'd0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_hold       <= (r_state == ST_HOLD) ? (r_hold + 4'd1) : 4'd0;
            r_core_reset <= (w_state_nxt != ST_RUN);
            r_done       <= is_terminal(w_state_nxt);
            r_pass       <= (w_state_nxt == ST_PASS);
            r_fail       <= (w_state_nxt == ST_FAIL);
            r_timeout    <= (w_state_nxt == ST_TIMEOUT);
        end
    end

    // The cycle leaving RUN is not counted, so a timeout freezes at LIMIT-1.
    assign w_cyc_en  = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
    assign w_ins_en  = (r_state == ST_RUN) && bus.instr_retire;
    assign w_cnt_clr = (r_state == ST_HOLD);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cyc_en),
        .o_count (cycle_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_instr_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_cnt_clr),
        .i_en    (w_ins_en),
        .o_count (instr_count)
    );

    assign core_reset = r_core_reset;
    assign done       = r_done;
    assign pass       = r_pass;
    assign fail       = r_fail;
    assign timeout    = r_timeout;
    assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_riscv_end_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_end_monitor
// Description : Directed vector bench for riscv_end_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_end_monitor;

    typedef struct {
        logic        rstn;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ret;
        logic [71:0] exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        core_reset, done, pass, fail, timeout;
    logic [2:0]  state_o;
    logic [31:0] cycle_count, instr_count;
    logic        core_reset4, done4, pass4, fail4, timeout4;
    logic [2:0]  state4;
    logic [3:0]  cycle4, instr4;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];

    riscv_end_monitor_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    riscv_end_monitor #(
        .ADDR_W(32), .DATA_W(32), .DONE_ADDR(32'd100), .PASS_VALUE(32'd25),
        .RESET_HOLD(4), .TIMEOUT_CYCLES(1000), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .core_reset(core_reset), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .state_o(state_o),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    riscv_end_monitor #(
        .ADDR_W(32), .DATA_W(32), .DONE_ADDR(32'd100), .PASS_VALUE(32'd25),
        .RESET_HOLD(4), .TIMEOUT_CYCLES(1000), .CNT_W(4)
    ) dut4 (
        .clk(clk), .reset(reset), .bus(bus),
        .core_reset(core_reset4), .done(done4), .pass(pass4), .fail(fail4),
        .timeout(timeout4), .state_o(state4),
        .cycle_count(cycle4), .instr_count(instr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] pk(input logic cr, dn, ps, fl, to,
                                       input logic [2:0] st,
                                       input logic [31:0] cyc, ins);
        return {cr, dn, ps, fl, to, st, cyc, ins};
    endfunction

    function automatic vec_t mk(input logic rstn, we, input logic [31:0] a, d,
                                input logic ret, input logic [71:0] e);
        vec_t v;
        v.rstn = rstn; v.we = we; v.addr = a; v.wdata = d; v.ret = ret; v.exp = e;
        return v;
    endfunction

    function automatic logic [71:0] act();
        return pk(core_reset, done, pass, fail, timeout, state_o, cycle_count, instr_count);
    endfunction

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, d, input logic ret);
        bus.mem_we = we; bus.mem_addr = a; bus.mem_wdata = d; bus.instr_retire = ret;
    endtask

    // Reset for one cycle, then release and walk through the hold window.
    task automatic reset_to_run();
        reset = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        reset = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0);

        // Power-up, hold window, retire 10, pass, then frozen.
        repeat (2) vecs.push_back(mk(0, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0)));
        repeat (3) vecs.push_back(mk(1, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1, 1, 0)));
        for (int i = 1; i <= 10; i++)
            vecs.push_back(mk(1, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 1, 32'(1 + i), 32'(i))));
        vecs.push_back(mk(1, 1, 100, 25, 0, pk(1, 1, 1, 0, 0, 2, 11, 10)));
        vecs.push_back(mk(1, 1, 100, 7, 1, pk(1, 1, 1, 0, 0, 2, 11, 10)));
        repeat (20) vecs.push_back(mk(1, 0, 0, 0, 1, pk(1, 1, 1, 0, 0, 2, 11, 10)));
        // Reset from PASS, hold-time write ignored, neighbour addresses, fail.
        vecs.push_back(mk(0, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 1, 100, 25, 0, pk(1, 0, 0, 0, 0, 0, 0, 0)));
        repeat (2) vecs.push_back(mk(1, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1, 0, 0)));
        vecs.push_back(mk(1, 1, 96, 25, 0, pk(0, 0, 0, 0, 0, 1, 1, 0)));
        vecs.push_back(mk(1, 1, 104, 25, 0, pk(0, 0, 0, 0, 0, 1, 2, 0)));
        vecs.push_back(mk(1, 0, 100, 25, 0, pk(0, 0, 0, 0, 0, 1, 3, 0)));
        vecs.push_back(mk(1, 1, 100, 7, 0, pk(1, 1, 0, 1, 0, 3, 3, 0)));
        vecs.push_back(mk(1, 1, 100, 25, 0, pk(1, 1, 0, 1, 0, 3, 3, 0)));

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rstn;
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ret);
            tick();
            chk($sformatf("vec%0d", i), act(), vecs[i].exp);
        end

        // Timeout after exactly 1000 RUN cycles.
        reset_to_run();
        repeat (999) tick();
        chk("timeout_pre", act(), pk(0, 0, 0, 0, 0, 1, 999, 0));
        tick();
        chk("timeout_hit", act(), pk(1, 1, 0, 0, 1, 4, 999, 0));
        tick();
        chk("timeout_frozen", act(), pk(1, 1, 0, 0, 1, 4, 999, 0));

        // Done write on the final cycle beats the timeout.
        reset_to_run();
        repeat (999) tick();
        drive(1, 100, 25, 0);
        tick();
        drive(0, 0, 0, 0);
        chk("done_beats_timeout", act(), pk(1, 1, 1, 0, 0, 2, 999, 0));

        // Asynchronous reset pulse mid-RUN, off any clock edge.
        reset_to_run();
        repeat (5) tick();
        chk("run5", act(), pk(0, 0, 0, 0, 0, 1, 5, 0));
        #2 reset = 1'b0;
        #0.5;
        chk("async_clear", act(), pk(1, 0, 0, 0, 0, 0, 0, 0));
        chk("async_clear4", 72'({core_reset4, state4, cycle4, instr4}), 72'({1'b1, 3'd0, 4'd0, 4'd0}));
        #0.5 reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("rehold%0d", k), act(), pk(1, 0, 0, 0, 0, 0, 0, 0));
        end
        tick();
        chk("rehold_run", act(), pk(0, 0, 0, 0, 0, 1, 0, 0));

        // Narrow counters saturate, wide ones keep counting.
        drive(0, 0, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("sat4_k%0d", k), 72'(instr4), 72'((k > 15) ? 15 : k));
            chk($sformatf("wide_k%0d", k), 72'(instr_count), 72'(k));
        end
        drive(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_end_monitor.md
Name: riscv_end_monitor

Overview:
Synthesizable run controller and end-of-program detector for the single-cycle RISC-V core. It sequences the core's reset and snoops the data-memory write port for a write to a fixed "done" address. It reports pass, fail or timeout, together with cycle and retired-instruction counts. Because it is on-chip, the same completion check that benches perform on the data RAM also works in silicon and FPGA builds.

Parameters:
ADDR_W, 32, data-memory address width
DATA_W, 32, data-memory write-data width
DONE_ADDR, 32'd100, byte address whose write ends the program
PASS_VALUE, 32'd25, write data that signals pass; any other value signals fail
RESET_HOLD, 4, cycles that core_reset stays asserted after the monitor leaves reset (1..15)
TIMEOUT_CYCLES, 1000, RUN cycles allowed before timeout (>=2)
CNT_W, 32, width of the cycle and instruction counters

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
mem_we  input  1  data-memory write enable from core
mem_addr  input  ADDR_W  data-memory byte address
mem_wdata  input  DATA_W  data-memory write data
instr_retire  input  1  one-cycle pulse per retired instruction
core_reset  output  1  active-high reset driven to the core
done  output  1  sticky; high in any terminal state
pass  output  1  sticky; done-address write carried PASS_VALUE
fail  output  1  sticky; done-address write carried another value
timeout  output  1  sticky; TIMEOUT_CYCLES elapsed without a done write
state_o  output  3  current FSM state encoding
cycle_count  output  CNT_W  RUN cycles elapsed
instr_count  output  CNT_W  instructions retired during RUN

Behaviour:
- Reset (reset==0, asynchronous): state=HOLD, hold counter=0, cycle_count=0, instr_count=0, core_reset=1, done/pass/fail/timeout=0.
- HOLD: core_reset=1. The hold counter increments each clk. When the counter reaches RESET_HOLD-1, the next state is RUN. core_reset therefore deasserts exactly RESET_HOLD cycles after reset rises.
- RUN: core_reset=0. cycle_count increments every clk. instr_count increments when instr_retire==1.
- Done write: mem_we==1 and mem_addr==DONE_ADDR (full-width compare). The next state is PASS if mem_wdata==PASS_VALUE, otherwise FAIL. The flag is registered, so it is visible 1 cycle after the write edge.
- Timeout: in RUN, when cycle_count==TIMEOUT_CYCLES-1 and there is no done write that cycle, the next state is TIMEOUT.
- Simultaneous done write and timeout condition: the done write wins (PASS or FAIL).
- Writes to any other address are ignored. Writes during HOLD are ignored.
- PASS/FAIL/TIMEOUT are terminal and sticky until reset. core_reset is reasserted to freeze the core. Counters freeze. Further writes are ignored.
- Exactly one of pass/fail/timeout is set when done==1. All three are 0 while done==0.
- Counters saturate at all-ones; they never wrap.
- Reset asserted mid-RUN or in a terminal state: all state clears immediately (asynchronously), and the HOLD sequence restarts on release.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- State encoding: HOLD=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4.

Decomposition:
- Package riscv_monitor_pkg:
  - mon_state_e enum (HOLD, RUN, PASS, FAIL, TIMEOUT; 3 bits).
  - Default DONE_ADDR and PASS_VALUE constants, shared with the core benches.
- One natural sub-module, sat_counter: a parameterised CNT_W saturating counter with clear and enable inputs. It is instantiated twice, for cycle_count and instr_count.
- The FSM and the hold counter stay in the top module.

Test Plan:
1. Reset pulse, then release; idle inputs -> core_reset=1 for exactly 4 cycles after release, then 0. state_o goes 0->1. cycle_count increments by 1 per clk.
2. In RUN, drive instr_retire high for 10 cycles, then mem_we=1, mem_addr=100, mem_wdata=25 -> the next cycle gives done=1, pass=1, fail=0, timeout=0, core_reset=1, instr_count=10. Counters then stay frozen for 20 further cycles.
3. Write mem_addr=100, mem_wdata=7 -> fail=1, pass=0, state_o=3. Earlier writes to addresses 96 and 104 with data 25 leave done=0.
4. No done write with TIMEOUT_CYCLES=1000 -> timeout=1 after exactly 1000 RUN cycles; cycle_count freezes at 999. A done write issued on that same final cycle instead yields pass=1, timeout=0.
5. Drive reset low for 1 ns mid-RUN, off any clock edge, and release -> all flags and counters are 0 and core_reset=1 immediately. The HOLD sequence then repeats.
6. With CNT_W=4 and instr_retire held high for 20 cycles -> instr_count saturates at 15 and does not wrap.
